// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - buffered UART transmitter: byte FIFO feeding an LSB-first serialiser
// Bit timing runs off the shared 16x clken tick; tx is always driven from a register.
module uart_transmitter #(
  parameter int FIFO_AW    = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  output logic       busy,
  output logic       tx
);

  localparam int   DEPTH     = 2 ** FIFO_AW;
  localparam logic ODD       = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0] count;
  logic [FIFO_AW:0] count_next;
  logic             push;
  logic             pop;

  state_t     state;
  logic [3:0] tick;
  logic [2:0] bitpos;
  logic       stop_cnt;
  logic [7:0] shift;
  logic       par_bit;
  logic [7:0] head;
  logic       stop_last;

  assign head      = mem[rd_ptr];
  assign stop_last = (stop_cnt == STOP_LAST);

  // Pops happen only on the clken that starts a frame, from IDLE or the final stop tick.
  always_comb begin
    push = wr_en && !full;
    pop  = 1'b0;
    if (clken && !empty) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == STOP && tick == 4'd15 && stop_last)
        pop = 1'b1;
    end
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_50m) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so the count MSB alone marks a full FIFO.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= count_next[FIFO_AW];
      empty <= (count_next == '0);
      ovf   <= wr_en && full;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= '0;
      bitpos   <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= head;
            par_bit <= (^head) ^ ODD;
            tick    <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          tick <= tick + 1'b1;
          if (tick == 4'd15) begin
            state  <= DATA;
            bitpos <= '0;
            tx     <= shift[0];
          end
        end
        DATA: begin
          tick <= tick + 1'b1;
          if (tick == 4'd15) begin
            if (bitpos == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              shift  <= {1'b0, shift[7:1]};
              bitpos <= bitpos + 1'b1;
              tx     <= shift[1];
            end
          end
        end
        PARITY: begin
          tick <= tick + 1'b1;
          if (tick == 4'd15) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end
        STOP: begin
          tick <= tick + 1'b1;
          if (tick == 4'd15) begin
            if (!stop_last) begin
              stop_cnt <= 1'b1;
            end else if (pop) begin
              shift   <= head;
              par_bit <= (^head) ^ ODD;
              tick    <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter over four parameter sets
// Instance 0 default, 1 even parity, 2 odd parity, 3 two stop bits.
module tb_uart_transmitter;

  localparam int N = 4;
  localparam logic [N-1:0] PEN   = 4'b0110;
  localparam logic [N-1:0] PODD  = 4'b0100;
  localparam logic [N-1:0] STOP2 = 4'b1000;

  logic         clk;
  logic         clken;
  logic         clken_en;
  int           div;
  logic [N-1:0] rst;
  logic [N-1:0] wr_en;
  logic [7:0]   din [N];
  wire  [N-1:0] full;
  wire  [N-1:0] empty;
  wire  [N-1:0] ovf;
  wire  [N-1:0] busy;
  wire  [N-1:0] tx;

  logic [8:0] exp_q [N][$];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_transmitter #(
      .FIFO_AW   (2),
      .PARITY_EN (PEN[g] ? 1 : 0),
      .PARITY_ODD(PODD[g] ? 1 : 0),
      .STOP_BITS (STOP2[g] ? 2 : 1)
    ) dut (
      .clk_50m(clk),
      .rst    (rst[g]),
      .clken  (clken),
      .din    (din[g]),
      .wr_en  (wr_en[g]),
      .full   (full[g]),
      .empty  (empty[g]),
      .ovf    (ovf[g]),
      .busy   (busy[g]),
      .tx     (tx[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clken = 1'b0;
    div   = 0;
    forever begin
      @(posedge clk);
      #1;
      div   = (div == 2) ? 0 : div + 1;
      clken = clken_en && (div == 2);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h required 0x%0h", name, k, act, expv);
    end
  endtask

  // Decodes one frame per start edge, checking each bit holds for 16 clken pulses.
  task automatic monitor(input int k);
    int         nbits;
    int         ticks;
    logic       v;
    logic       aborted;
    logic       unstable;
    logic [11:0] bits;
    logic [11:0] eb;
    logic [8:0]  e;
    forever begin
      @(negedge clk);
      if (!rst[k] && tx[k] == 1'b0) begin
        nbits    = 10 + int'(PEN[k]) + int'(STOP2[k]);
        bits     = '1;
        aborted  = 1'b0;
        unstable = 1'b0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          v     = tx[k];
          ticks = 0;
          while (ticks < 16) begin
            if (rst[k]) begin
              aborted = 1'b1;
              break;
            end
            if (tx[k] !== v) unstable = 1'b1;
            if (clken) ticks++;
            if (ticks < 16) @(negedge clk);
          end
          bits[b] = v;
          if (!aborted && b < nbits - 1) @(negedge clk);
        end
        if (!aborted) begin
          if (exp_q[k].size() == 0) begin
            check("unexpected_frame", k, {20'b0, bits}, 32'hFFF);
          end else begin
            e  = exp_q[k].pop_front();
            eb = '1;
            eb[0]   = 1'b0;
            eb[8:1] = e[7:0];
            if (PEN[k]) eb[9] = e[8];
            check("frame", k, {19'b0, unstable, bits}, {20'b0, eb});
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      automatic int k = i;
      fork
        monitor(k);
      join_none
    end
  end

  task automatic push(input int k, input logic [7:0] d, input logic par, input logic accept);
    @(posedge clk);
    #1;
    wr_en[k] = 1'b1;
    din[k]   = d;
    if (accept) exp_q[k].push_back({par, d});
  endtask

  task automatic stop_wr(input int k);
    @(posedge clk);
    #1;
    wr_en[k] = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (clken) c++;
    end
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while ((!empty[k] || busy[k]) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30000) check("idle_timeout", k, {31'b0, busy[k]}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic measure_busy(input int k, output int n, output logic nonempty);
    int t = 0;
    n        = 0;
    nonempty = 1'b0;
    while (!busy[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    while (busy[k] && t < 30000) begin
      if (clken) n++;
      if (!empty[k]) nonempty = 1'b1;
      @(negedge clk);
      t++;
    end
  endtask

  int   n;
  int   ovf_n;
  int   busy_n;
  logic ne;

  initial begin
    rst      = '1;
    wr_en    = '0;
    clken_en = 1'b1;
    for (int i = 0; i < N; i++) din[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      check("reset_state", i, {27'b0, tx[i], busy[i], empty[i], full[i], ovf[i]}, 32'b10100);
    @(posedge clk);
    #1;
    rst = '0;

    push(0, 8'h55, 1'b0, 1'b1);
    stop_wr(0);
    measure_busy(0, n, ne);
    check("single_busy_ticks", 0, n, 32'd160);
    check("single_empty_low", 0, {31'b0, ne}, 32'd0);
    wait_idle(0);

    push(1, 8'h07, 1'b1, 1'b1);
    stop_wr(1);
    measure_busy(1, n, ne);
    check("parity_even_ticks", 1, n, 32'd176);
    wait_idle(1);

    push(2, 8'h07, 1'b0, 1'b1);
    stop_wr(2);
    measure_busy(2, n, ne);
    check("parity_odd_ticks", 2, n, 32'd176);
    wait_idle(2);

    push(3, 8'h00, 1'b0, 1'b1);
    stop_wr(3);
    measure_busy(3, n, ne);
    check("stop2_ticks", 3, n, 32'd176);
    wait_idle(3);

    push(0, 8'hA5, 1'b0, 1'b1);
    push(0, 8'h3C, 1'b0, 1'b1);
    push(0, 8'hFF, 1'b0, 1'b1);
    stop_wr(0);
    measure_busy(0, n, ne);
    check("b2b_busy_ticks", 0, n, 32'd480);
    wait_idle(0);

    clken_en = 1'b0;
    repeat (2) @(posedge clk);
    ovf_n = 0;
    fork
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (ovf[0]) ovf_n++;
        end
      end
      begin
        push(0, 8'h11, 1'b0, 1'b1);
        push(0, 8'h22, 1'b0, 1'b1);
        push(0, 8'h33, 1'b0, 1'b1);
        push(0, 8'h44, 1'b0, 1'b1);
        push(0, 8'h55, 1'b0, 1'b0);
        stop_wr(0);
      end
    join
    check("ovf_pulses", 0, ovf_n, 32'd1);
    check("full_after_4", 0, {31'b0, full[0]}, 32'd1);
    clken_en = 1'b1;
    wait_idle(0);
    check("ovf_frames_drained", 0, exp_q[0].size(), 32'd0);

    push(0, 8'hC3, 1'b0, 1'b1);
    push(0, 8'h5A, 1'b0, 1'b1);
    push(0, 8'h81, 1'b0, 1'b1);
    stop_wr(0);
    n = 0;
    while (!busy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    wait_ticks(40);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    exp_q[0].delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_midframe", 0, {29'b0, tx[0], busy[0], empty[0]}, 32'b101);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (busy[0] || !tx[0]) busy_n++;
    end
    check("no_frames_after_reset", 0, busy_n, 32'd0);

    for (int i = 0; i < N; i++)
      check("queue_empty_at_end", i, exp_q[i].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Buffered UART transmitter for the host serial link; the transmit-side counterpart of the UART receive path. It accepts bytes over a write strobe into a small FIFO and serialises each one LSB-first as start, 8 data bits, optional parity and 1–2 stop bits on `tx`. Bit timing comes from the same 16× oversampling `clken` tick that drives the receive side, so both directions share one baud generator.

## Interface
- `FIFO_AW`, default 2: FIFO address width; depth = 2**FIFO_AW entries (default 4).
- `PARITY_EN`, default 0: 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 and 2.

- `clk_50m`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `clken`  in  1  16× baud tick, one `clk_50m` cycle wide.
- `din`  in  8  byte to transmit.
- `wr_en`  in  1  write strobe; pushes `din` when `full`=0.
- `full`  out  1  FIFO holds 2**FIFO_AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `ovf`  out  1  one-cycle pulse: a write was dropped because the FIFO was full.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `tx`  out  1  serial line; idle level is high.

## Operation
- FIFO: circular buffer with read/write pointers and an (FIFO_AW+1)-bit count. `full` and `empty` are registered and derived from the count.
- Writes: `wr_en` while `full`=1 is dropped and pulses `ovf`, even if a pop occurs in the same cycle. Otherwise a write and a pop in the same cycle both take effect and the count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All FSM activity advances only on cycles where `clken`=1.
- A 4-bit `tick` counter counts `clken` pulses within a bit; each bit lasts 16 ticks.
- IDLE: on `clken` with `empty`=0, pop the FIFO head into the shift register, clear `tick`, drive `tx`=0 and go to START.
- START: after 16 ticks go to DATA with `bitpos`=0; `tx` = shift[0].
- DATA: every 16 ticks shift right and increment `bitpos`. After bit 7 completes:
  - go to PARITY if `PARITY_EN`=1;
  - otherwise go to STOP.
- Parity value is the XOR of the 8 data bits, XORed with `PARITY_ODD`. It is computed at pop time.
- PARITY: `tx` = parity bit for 16 ticks, then go to STOP.
- STOP: `tx`=1 for 16×STOP_BITS ticks, using a stop-bit counter. At the last tick:
  - if `empty`=0, pop the next byte and go directly to START with `tx`=0 (back-to-back frames, no idle gap);
  - else go to IDLE.
- `tx` is driven from a register; no combinational path from `din` or `wr_en` to `tx`.
- Undefined state encodings return to IDLE with `tx`=1.

## Timing
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `ovf`=0, FSM=IDLE, pointers, count and `tick`=0.
- Reset mid-frame flushes the FIFO; `tx` is 1 on the cycle after `rst` is sampled.
- `wr_en` at cycle N: `empty` falls at N+1. The earliest pop is on the first `clken` at cycle ≥ N+1; `tx` falls and `busy` rises one cycle after that `clken`.
- Frame length is (10 + PARITY_EN + STOP_BITS − 1) × 16 `clken` ticks, measured from the falling edge of `tx` to the next possible start edge.
- A pop decrements the count the cycle after the popping `clken`; `full` deasserts at the same time.
- `ovf` is asserted in the cycle after the dropped `wr_en`.
- Each `tx` bit is stable for exactly 16 `clken` pulses.

## Test plan
- Single byte, defaults: write 0x55 → `tx` shows 0, 1,0,1,0,1,0,1,0, 1; each bit lasts 16 ticks; `busy` falls after 160 ticks and `empty`=1 throughout the frame.
- Parity: PARITY_EN=1, PARITY_ODD=0, write 0x07 → parity bit = 1. With PARITY_ODD=1 → parity bit = 0. Frame = 176 ticks.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles → three contiguous frames; stop bit → start bit with no extra tick; `busy` stays high for 480 ticks.
- Overflow: with `clken` held low, write 5 bytes → 4 accepted, `full`=1, one `ovf` pulse on the 5th. Release `clken` → exactly 4 frames are sent, in write order.
- STOP_BITS=2: write 0x00 → `tx` high for 32 ticks after bit 7; total frame 176 ticks.
- Reset mid-frame: assert `rst` during DATA with 2 bytes queued → next cycle `tx`=1, `busy`=0, `empty`=1; no further frames are sent without new writes.
